// File: rtl/block_copy_dma_if.sv
// Bus bundle for block_copy_dma: copy request/status, memory read port and memory write port.
// The master modport is the DMA's view of the bus; the slave modport is the host/memory view.
interface block_copy_dma_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] src;
  logic [WORD_W-1:0] dst;
  logic [WORD_W-1:0] len;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] read_bus;
  logic              read_en;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] write_bus;
  logic              write_en;
  logic [WORD_W-1:0] data_out;

  modport master (
    input  start, abort, src, dst, len, data_in,
    output busy, done, read_bus, read_en, write_bus, write_en, data_out
  );

  modport slave (
    output start, abort, src, dst, len, data_in,
    input  busy, done, read_bus, read_en, write_bus, write_en, data_out
  );
endinterface

// File: rtl/block_copy_dma.sv
// Single-channel word-copy DMA: read, capture, write, 3 cycles per word, ascending addresses.
// Define BLOCK_COPY_FILL_EN to add the fill_mode port (write src as a constant, 1 cycle per word).
module block_copy_dma #(
  parameter int                WORD_W    = 16,
  parameter logic [WORD_W-1:0] IDLE_ADDR = 16'h0000
) (
  input  logic clk,
  input  logic reset,
`ifdef BLOCK_COPY_FILL_EN
  input  logic fill_mode,
`endif
  block_copy_dma_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] src_cur_reg;
  logic [WORD_W-1:0] dst_cur_reg;
  logic [WORD_W-1:0] remaining_reg;
  logic [WORD_W-1:0] buffer_reg;
  logic              fill_active;
  logic              accept;

  // abort has priority over start, so a simultaneous pair never launches a copy
  assign accept = (state_reg == IDLE) && bus.start && !bus.abort;

`ifdef BLOCK_COPY_FILL_EN
  logic fill_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_reg <= 1'b0;
    end else if (accept) begin
      fill_reg <= fill_mode;
    end
  end

  assign fill_active = fill_reg;
`else
  assign fill_active = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.len == '0) begin
            state_next = FIN;
          end else if (fill_active_on_start()) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:  state_next = CAP;
      CAP: state_next = WR;
      WR: begin
        if (remaining_reg == WORD_W'(1)) begin
          state_next = FIN;
        end else if (fill_active) begin
          state_next = WR;
        end else begin
          state_next = RD;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && bus.abort) begin
      state_next = IDLE;
    end
  end

  // Fill mode is decided by the value presented with start, before fill_reg is loaded
  function automatic logic fill_active_on_start();
`ifdef BLOCK_COPY_FILL_EN
    return fill_mode;
`else
    return 1'b0;
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_cur_reg   <= '0;
      dst_cur_reg   <= '0;
      remaining_reg <= '0;
      buffer_reg    <= '0;
    end else begin
      if (accept) begin
        src_cur_reg   <= bus.src;
        dst_cur_reg   <= bus.dst;
        remaining_reg <= bus.len;
      end
      if (state_reg == CAP) begin
        buffer_reg <= bus.data_in;
      end
      // In fill mode src_cur holds the fill value, so it must not advance
      if (state_reg == WR) begin
        if (!fill_active) begin
          src_cur_reg <= src_cur_reg + WORD_W'(1);
        end
        dst_cur_reg   <= dst_cur_reg + WORD_W'(1);
        remaining_reg <= remaining_reg - WORD_W'(1);
      end
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == FIN) && !bus.abort;
  assign bus.read_en   = (state_reg == RD);
  assign bus.read_bus  = bus.read_en ? src_cur_reg : IDLE_ADDR;
  assign bus.write_en  = (state_reg == WR);
  assign bus.write_bus = bus.write_en ? dst_cur_reg : IDLE_ADDR;
  assign bus.data_out  = bus.write_en ? (fill_active ? src_cur_reg : buffer_reg) : '0;

endmodule

// File: tb/tb_block_copy_dma.sv
// Scoreboard bench for block_copy_dma: expected reads/writes are queued at launch and
// popped by a negedge monitor; a behavioural memory answers reads and absorbs writes.
module tb_block_copy_dma;
  localparam int WORD_W = 16;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic clk;
  logic reset;
  logic fill_mode;

  block_copy_dma_if #(.WORD_W(WORD_W)) bus ();

  block_copy_dma #(.WORD_W(WORD_W), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef BLOCK_COPY_FILL_EN
    .fill_mode (fill_mode),
`endif
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int done_count = 0;
  int done_at = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_q[$];
  logic [31:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data is valid the cycle after read_en; writes land on the edge
  always @(posedge clk) begin
    if (bus.read_en) bus.data_in <= mem[bus.read_bus];
    if (bus.write_en) mem[bus.write_bus] <= bus.data_out;
  end

  always @(negedge clk) begin
    check("strobe_excl", {31'b0, bus.read_en & bus.write_en}, 32'd0);
    if (bus.read_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", {16'b0, bus.read_bus}, 32'hFFFF_FFFF);
      else begin
        logic [15:0] a;
        a = rd_q.pop_front();
        check("rd_addr", {16'b0, bus.read_bus}, {16'b0, a});
        $display("read  addr=%h", bus.read_bus);
      end
    end else begin
      check("rd_idle_addr", {16'b0, bus.read_bus}, {16'b0, IDLE_ADDR});
    end
    if (bus.write_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", {bus.write_bus, bus.data_out}, 32'hFFFF_FFFF);
      else begin
        logic [31:0] e;
        e = wr_q.pop_front();
        check("wr_addr_data", {bus.write_bus, bus.data_out}, e);
        $display("write addr=%h data=%h", bus.write_bus, bus.data_out);
      end
    end else begin
      check("wr_idle", {bus.write_bus, bus.data_out}, {IDLE_ADDR, 16'h0000});
    end
    if (bus.done) begin
      done_count <= done_count + 1;
      done_at    <= cyc - t0 + 1;
      $display("done  at cycle %0d after start", cyc - t0 + 1);
    end
  end

  // Returns #1 into cycle 1 (the first cycle after the accepting edge)
  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input logic f);
    bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = l; fill_mode = f;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src = 16'h0; bus.dst = 16'h0; bus.len = 16'h0; fill_mode = 1'b0;
    t0 = cyc;
    check("busy_cycle1", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycle);
    int dc0;
    int k;
    dc0 = done_count;
    k = 0;
    while (done_count == dc0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, done_count - dc0, 1);
    check({tag, "_done_cycle"}, done_at, exp_cycle);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_rdq_empty"}, rd_q.size(), 0);
    check({tag, "_wrq_empty"}, wr_q.size(), 0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; fill_mode = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.busy, bus.done, bus.read_en, bus.write_en, bus.read_bus, bus.write_bus},
          {4'b0, IDLE_ADDR, IDLE_ADDR});
    check("rst_data_out", {16'b0, bus.data_out}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic 4-word copy
    for (int i = 0; i < 4; i++) begin
      mem[16'h0100 + i] = 16'(i + 1);
      rd_q.push_back(16'h0100 + 16'(i));
      wr_q.push_back({16'h0200 + 16'(i), 16'(i + 1)});
    end
    launch(16'h0100, 16'h0200, 16'd4, 1'b0);
    wait_done("len4", 13);

    // Zero-length copy: FIN immediately, busy for one cycle
    launch(16'h0700, 16'h0800, 16'd0, 1'b0);
    wait_done("len0", 1);

    // Source address wraps through 0xFFFF
    mem[16'hFFFE] = 16'hA1; mem[16'hFFFF] = 16'hA2; mem[16'h0000] = 16'hA3;
    rd_q.push_back(16'hFFFE); rd_q.push_back(16'hFFFF); rd_q.push_back(16'h0000);
    wr_q.push_back({16'h0010, 16'h00A1});
    wr_q.push_back({16'h0011, 16'h00A2});
    wr_q.push_back({16'h0012, 16'h00A3});
    launch(16'hFFFE, 16'h0010, 16'd3, 1'b0);
    wait_done("wrap", 10);

    // Overlap dst = src+1: the first word is propagated forward
    mem[16'h0400] = 16'h11; mem[16'h0401] = 16'h22; mem[16'h0402] = 16'h33;
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(16'h0400 + 16'(i));
      wr_q.push_back({16'h0401 + 16'(i), 16'h0011});
    end
    launch(16'h0400, 16'h0401, 16'd3, 1'b0);
    wait_done("overlap", 10);
    check("overlap_mem", {16'b0, mem[16'h0403]}, 32'h11);

    // start while busy is ignored
    mem[16'h0500] = 16'h5A; mem[16'h0501] = 16'h5B;
    rd_q.push_back(16'h0500); rd_q.push_back(16'h0501);
    wr_q.push_back({16'h0600, 16'h005A}); wr_q.push_back({16'h0601, 16'h005B});
    launch(16'h0500, 16'h0600, 16'd2, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.src = 16'h0900; bus.dst = 16'h0A00; bus.len = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src = 16'h0; bus.dst = 16'h0; bus.len = 16'h0;
    wait_done("start_busy", 7);

    // Abort in the CAP cycle of word 2: one write, no done
    for (int i = 0; i < 4; i++) mem[16'h0B00 + i] = 16'h0C0 + 16'(i);
    rd_q.push_back(16'h0B00); rd_q.push_back(16'h0B01);
    wr_q.push_back({16'h0D00, 16'h00C0});
    dc = done_count;
    launch(16'h0B00, 16'h0D00, 16'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_idle", {31'b0, bus.busy}, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_done", done_count - dc, 0);
    check("abort_rdq_empty", rd_q.size(), 0);
    check("abort_wrq_empty", wr_q.size(), 0);

    // abort and start together in IDLE: no copy
    bus.start = 1'b1; bus.abort = 1'b1; bus.src = 16'h0E00; bus.dst = 16'h0F00; bus.len = 16'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start_idle", {31'b0, bus.busy}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_start_no_done", done_count - dc, 0);

    // Reset during WR of word 1
    mem[16'h1000] = 16'h77;
    rd_q.push_back(16'h1000);
    launch(16'h1000, 16'h1100, 16'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_ctrl", {28'b0, bus.busy, bus.done, bus.read_en, bus.write_en}, 32'd0);
    check("midrst_bus", {bus.read_bus, bus.write_bus}, {IDLE_ADDR, IDLE_ADDR});
    check("midrst_data_out", {16'b0, bus.data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_count - dc, 0);
    check("midrst_rdq_empty", rd_q.size(), 0);

`ifdef BLOCK_COPY_FILL_EN
    for (int i = 0; i < 3; i++) wr_q.push_back({16'h0300 + 16'(i), 16'hBEEF});
    launch(16'hBEEF, 16'h0300, 16'd3, 1'b1);
    wait_done("fill", 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
